// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } lsu_state_t;

   localparam logic [3:0] BE_WORD  = 4'b1111;
   localparam logic [3:0] BE_BYTE0 = 4'b0001;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication and load-lane extraction.
import lsu_pkg::*;

module lsu_align (
   input  logic [1:0]  offset,
   input  logic        is_byte,
   input  logic [31:0] store_data,
   input  logic [31:0] load_data,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic [31:0] load_value
);

   always_comb begin
      byte_en    = BE_WORD;
      wdata      = store_data;
      load_value = load_data;
      if (is_byte) begin
         byte_en = BE_BYTE0 << offset;
         wdata   = {4{store_data[7:0]}};
         case (offset)
            2'd0:    load_value = {24'b0, load_data[7:0]};
            2'd1:    load_value = {24'b0, load_data[15:8]};
            2'd2:    load_value = {24'b0, load_data[23:16]};
            default: load_value = {24'b0, load_data[31:24]};
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/BUSY/DONE bus sequencer with byte/word support.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
import lsu_pkg::*;

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        load_byte,
   input  logic        store_byte,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   output logic        dbus_read,
   output logic        dbus_write,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic [31:0] memory_value,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_error
);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        write_q;
   logic        byte_q;
   logic        misaligned_q;
   logic        timeout_hit;
   logic        request;
   logic        req_byte;
   logic        req_misaligned;
   logic [3:0]  be_aligned;
   logic [31:0] load_value;

   // A simultaneous read+write is treated purely as a store.
   assign request        = mem_read | mem_write;
   assign req_byte       = mem_write ? store_byte : load_byte;
   assign req_misaligned = !req_byte && (address[1:0] != 2'b00);

   lsu_align u_align (
      .offset     (addr_q[1:0]),
      .is_byte    (byte_q),
      .store_data (data_q),
      .load_data  (dbus_rdata),
      .byte_en    (be_aligned),
      .wdata      (dbus_wdata),
      .load_value (load_value)
   );

   assign dbus_addr  = {addr_q[31:2], 2'b00};
   assign dbus_be    = (state_q == BUSY) ? be_aligned : 4'b0000;
   assign misaligned = misaligned_q;

   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      dbus_read  = 1'b0;
      dbus_write = 1'b0;
      case (state_q)
         IDLE: begin
            if (request) begin
               stall   = 1'b1;
               state_d = req_misaligned ? DONE : BUSY;
            end
         end
         BUSY: begin
            stall      = 1'b1;
            dbus_read  = !write_q;
            dbus_write = write_q;
            if (dbus_ack || timeout_hit) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         write_q      <= 1'b0;
         byte_q       <= 1'b0;
         misaligned_q <= 1'b0;
         memory_value <= '0;
      end else begin
         state_q      <= state_d;
         misaligned_q <= (state_q == IDLE) && request && req_misaligned;
         if (state_q == IDLE && request) begin
            addr_q  <= address;
            data_q  <= store_data;
            write_q <= mem_write;
            byte_q  <= req_byte;
         end
         if (state_q == BUSY && dbus_ack && !write_q) begin
            memory_value <= load_value;
         end
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [TW-1:0] timeout_cnt;
   logic          bus_error_q;

   // Counts completed BUSY cycles; the last allowed cycle without ack aborts.
   assign timeout_hit = (state_q == BUSY) && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign bus_error   = bus_error_q;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         timeout_cnt <= '0;
         bus_error_q <= 1'b0;
      end else begin
         timeout_cnt <= (state_q == BUSY) ? timeout_cnt + TW'(1) : '0;
         bus_error_q <= (state_q == BUSY) && !dbus_ack && timeout_hit;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_error   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard-driven bench for load_store_unit: bus transactions queued at issue, checked at service.
module tb_load_store_unit;

   logic        clk;
   logic        nRst;
   logic        mem_read;
   logic        mem_write;
   logic        load_byte;
   logic        store_byte;
   logic [31:0] address;
   logic [31:0] store_data;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_read;
   logic        dbus_write;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;
   logic [31:0] memory_value;
   logic        stall;
   logic        misaligned;
   logic        bus_error;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] mem_value;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          errors;
   int          stall_seen;
   logic [31:0] model_mem;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .nRst         (nRst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .load_byte    (load_byte),
      .store_byte   (store_byte),
      .address      (address),
      .store_data   (store_data),
      .dbus_addr    (dbus_addr),
      .dbus_wdata   (dbus_wdata),
      .dbus_be      (dbus_be),
      .dbus_read    (dbus_read),
      .dbus_write   (dbus_write),
      .dbus_rdata   (dbus_rdata),
      .dbus_ack     (dbus_ack),
      .memory_value (memory_value),
      .stall        (stall),
      .misaligned   (misaligned),
      .bus_error    (bus_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one request for a single cycle and queues the expected bus transaction.
   task automatic issue(input logic rd, input logic wr, input logic lb, input logic sbyte,
                        input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata);
      exp_t        e;
      logic        byte_acc;
      logic [31:0] shifted;
      byte_acc = wr ? sbyte : lb;
      @(posedge clk);
      #1;
      mem_read   = rd;
      mem_write  = wr;
      load_byte  = lb;
      store_byte = sbyte;
      address    = addr;
      store_data = data;
      stall_seen = 0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL issue_stall got %b want 1", stall);
      end
      if (stall === 1'b1) stall_seen++;
      if (byte_acc || addr[1:0] == 2'b00) begin
         e.write = wr;
         e.addr  = {addr[31:2], 2'b00};
         e.be    = byte_acc ? (4'b0001 << addr[1:0]) : 4'b1111;
         e.wdata = byte_acc ? {data[7:0], data[7:0], data[7:0], data[7:0]} : data;
         e.rdata = rdata;
         shifted = rdata >> (8 * addr[1:0]);
         e.mem_value = byte_acc ? {24'b0, shifted[7:0]} : rdata;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      load_byte  = 1'b0;
      store_byte = 1'b0;
      address    = 32'hFFFF_FFFF;
      store_data = 32'hFFFF_FFFF;
   endtask

   // Services the oldest queued transaction, acking in the given BUSY cycle, then checks DONE.
   task automatic serve(input int delay);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL serve_queue got 0 entries want 1");
         return;
      end
      e = sb.pop_front();
      for (int i = 1; i <= delay; i++) begin
         @(negedge clk);
         if (stall === 1'b1) stall_seen++;
         checks++;
         if ({dbus_read, dbus_write} !== {!e.write, e.write}) begin
            errors++;
            $display("FAIL busy_strobes got %b%b want %b%b", dbus_read, dbus_write, !e.write, e.write);
         end
         if (i == 1) begin
            checks++;
            if (dbus_addr !== e.addr) begin
               errors++;
               $display("FAIL dbus_addr got %h want %h", dbus_addr, e.addr);
            end
            if (e.write) begin
               checks++;
               if (dbus_be !== e.be) begin
                  errors++;
                  $display("FAIL dbus_be got %b want %b", dbus_be, e.be);
               end
               checks++;
               if (dbus_wdata !== e.wdata) begin
                  errors++;
                  $display("FAIL dbus_wdata got %h want %h", dbus_wdata, e.wdata);
               end
            end
         end
         if (i == delay) begin
            dbus_ack   = 1'b1;
            dbus_rdata = e.rdata;
         end
      end
      @(posedge clk);
      #1;
      dbus_ack   = 1'b0;
      dbus_rdata = 32'h5A5A_5A5A;
      if (!e.write) model_mem = e.mem_value;
      @(negedge clk);
      checks++;
      if ({stall, dbus_read, dbus_write, misaligned, bus_error} !== 5'b0) begin
         errors++;
         $display("FAIL done_flags got %b want 00000",
                  {stall, dbus_read, dbus_write, misaligned, bus_error});
      end
      checks++;
      if (memory_value !== model_mem) begin
         errors++;
         $display("FAIL done_memory_value got %h want %h", memory_value, model_mem);
      end
      @(posedge clk);
   endtask

   task automatic test_reset;
      nRst       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      load_byte  = 1'b0;
      store_byte = 1'b0;
      address    = '0;
      store_data = '0;
      dbus_rdata = '0;
      dbus_ack   = 1'b0;
      model_mem  = '0;
      #12;
      checks++;
      if ({stall, dbus_read, dbus_write, misaligned, bus_error, dbus_be} !== 9'b0 ||
          dbus_addr !== 32'h0 || dbus_wdata !== 32'h0 || memory_value !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got flags %b addr %h wdata %h mv %h want all 0",
                  {stall, dbus_read, dbus_write, misaligned, bus_error, dbus_be},
                  dbus_addr, dbus_wdata, memory_value);
      end
      @(posedge clk);
      #1 nRst = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall, dbus_read, dbus_write} !== 3'b0) begin
         errors++;
         $display("FAIL idle_quiet got %b want 000", {stall, dbus_read, dbus_write});
      end
   endtask

   task automatic test_word_load;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
      serve(3);
      checks++;
      if (stall_seen != 4) begin
         errors++;
         $display("FAIL word_load_stall_cycles got %0d want 4", stall_seen);
      end
   endtask

   task automatic test_byte_load;
      for (int lane = 0; lane < 4; lane++) begin
         issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100 + lane, 32'h0, 32'hAABB_CCDD);
         serve(1);
         checks++;
         if (stall_seen != 2) begin
            errors++;
            $display("FAIL min_latency_stall got %0d want 2", stall_seen);
         end
      end
   endtask

   task automatic test_byte_store;
      issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0202, 32'h1234_5678, 32'h0);
      serve(2);
      issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0201, 32'h0000_00C3, 32'h0);
      serve(1);
   endtask

   task automatic test_word_store;
      issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h1111_2222);
      serve(2);
   endtask

   task automatic test_misaligned;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0101, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({misaligned, dbus_read, dbus_write, stall} !== 4'b1000) begin
         errors++;
         $display("FAIL misaligned_done got %b want 1000", {misaligned, dbus_read, dbus_write, stall});
      end
      checks++;
      if (memory_value !== model_mem) begin
         errors++;
         $display("FAIL misaligned_mv got %h want %h", memory_value, model_mem);
      end
      @(negedge clk);
      checks++;
      if (misaligned !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_clear got %b want 0", misaligned);
      end
   endtask

   task automatic test_stray_ack;
      @(posedge clk);
      #1;
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h9999_9999;
      @(posedge clk);
      #1 dbus_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (memory_value !== model_mem || stall !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack got mv %h stall %b want mv %h stall 0", memory_value, stall, model_mem);
      end
   endtask

   task automatic test_reset_mid_busy;
      exp_t dropped;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 32'h7777_8888);
      dropped = sb.pop_front();
      @(negedge clk);
      checks++;
      if (dbus_read !== 1'b1) begin
         errors++;
         $display("FAIL busy_before_reset got %b want 1", dbus_read);
      end
      #2 nRst = 1'b0;
      #1;
      model_mem = '0;
      checks++;
      if ({dbus_read, stall, dbus_be} !== 6'b0 || memory_value !== 32'h0 || dbus_addr !== 32'h0) begin
         errors++;
         $display("FAIL async_reset got rd %b stall %b be %b mv %h addr %h want all 0",
                  dbus_read, stall, dbus_be, memory_value, dbus_addr);
      end
      @(posedge clk);
      #1 nRst = 1'b1;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_CAFE);
      serve(2);
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout;
      exp_t dropped;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 32'h1234_4321);
      dropped = sb.pop_front();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (dbus_read !== 1'b1 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy cycle %0d got rd %b err %b want 1 0", i, dbus_read, bus_error);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus_error, stall, dbus_read} !== 3'b100 || memory_value !== model_mem) begin
         errors++;
         $display("FAIL timeout_done got err/stall/rd %b mv %h want 100 mv %h",
                  {bus_error, stall, dbus_read}, memory_value, model_mem);
      end
      @(negedge clk);
      checks++;
      if ({bus_error, stall} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_idle got %b want 00", {bus_error, stall});
      end
   endtask
`else
   task automatic test_timeout;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 32'h1234_4321);
      serve(12);
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_word_load();
      test_byte_load();
      test_byte_store();
      test_word_store();
      test_misaligned();
      test_stray_ack();
      test_reset_mid_busy();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of BUSY cycles without dbus_ack before abort (used only with LSU_TIMEOUT_EN).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- nRst  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from execute stage.
- mem_write  in  1  store request from execute stage.
- load_byte  in  1  byte load, zero-extended.
- store_byte  in  1  byte store.
- address  in  32  effective address from ALU.
- store_data  in  32  rs2 value.
- dbus_addr  out  32  word-aligned bus address.
- dbus_wdata  out  32  bus write data.
- dbus_be  out  4  byte enables.
- dbus_read  out  1  bus read strobe.
- dbus_write  out  1  bus write strobe.
- dbus_rdata  in  32  bus read data, valid with dbus_ack.
- dbus_ack  in  1  bus completion.
- memory_value  out  32  registered load result to writeback.
- stall  out  1  freeze upstream pipeline.
- misaligned  out  1  word access with address[1:0]!=0, held one cycle in DONE.
- bus_error  out  1  timeout abort, held one cycle in DONE.

Function
REQ-003 FSM states SHALL be IDLE, BUSY, DONE.
REQ-004 IDLE: if mem_read|mem_write, latch address, data, byte flags; stall=1 combinationally in the same cycle; next state BUSY.
REQ-005 Simultaneous mem_read and mem_write SHALL perform only the store.
REQ-006 Word access with address[1:0]!=0 SHALL skip the bus, go IDLE->DONE, assert misaligned, and leave memory_value unchanged.
REQ-007 BUSY: dbus_read or dbus_write=1, stall=1; dbus_addr={addr[31:2],2'b00}; strobes held until the cycle dbus_ack=1.
REQ-008 Word store: dbus_be=4'b1111, dbus_wdata=store_data.
REQ-009 Byte store: dbus_be=4'b0001<<addr[1:0], dbus_wdata=store_data[7:0] replicated to all four lanes.
REQ-010 On ack for a word load, memory_value<=dbus_rdata; for a byte load, {24'b0, lane addr[1:0]}.
REQ-011 On ack, next state SHALL be DONE; stores SHALL NOT alter memory_value.
REQ-012 DONE: stall=0, strobes=0 for exactly one cycle; next state IDLE unconditionally, with inputs sampled again in IDLE.
REQ-013 Minimum latency: ack in the first BUSY cycle gives 2 stall cycles, then DONE.
REQ-014 dbus_ack outside BUSY SHALL be ignored.
REQ-015 With no request, stall=0 and strobes=0 in IDLE.

Reset
REQ-016 nRst low SHALL immediately force IDLE, memory_value=0, all strobes, stall, misaligned and bus_error=0, dbus_be=0, addr/wdata=0, including mid-BUSY.
REQ-017 The first request after reset release SHALL be handled normally from IDLE.

Configuration
REQ-018 Macro LSU_TIMEOUT_EN: when defined, an 8+ bit counter SHALL count BUSY cycles; at TIMEOUT_CYCLES without ack -> DONE with bus_error=1, memory_value unchanged.
REQ-019 Without LSU_TIMEOUT_EN, BUSY SHALL wait indefinitely, and bus_error SHALL be tied 0.

Structure
REQ-020 Package lsu_pkg SHALL hold the lsu_state_t enum (IDLE/BUSY/DONE), BE_WORD=4'b1111, and BE_BYTE0=4'b0001.
REQ-021 Sub-module lsu_align (combinational) SHALL generate byte enables, replicate store data and extract load lanes.

Verification
REQ-022 Word load addr=0x100, ack after 3 BUSY cycles with rdata=0xDEADBEEF -> stall high 4 cycles, dbus_addr=0x100, memory_value=0xDEADBEEF in DONE.
REQ-023 Byte load addr=0x103, rdata=0xAABBCCDD -> memory_value=0x000000AA.
REQ-024 Byte store addr=0x202, store_data=0x12345678 -> dbus_be=4'b0100, dbus_wdata=0x78787878, dbus_addr=0x200.
REQ-025 Word load addr=0x101 -> no strobe, misaligned=1 for one cycle, memory_value unchanged.
REQ-026 nRst pulsed low in BUSY -> dbus_read=0 and stall=0 asynchronously, then a fresh word load completes.
REQ-027 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_error=1 after 4 BUSY cycles, then IDLE.
